// File: rtl/bus_arbiter_rr_if.sv
// Local-bus arbitration handshake bundle: active-low request/acknowledge/strobe in,
// active-low grant plus owner/status flags out of the arbiter.
interface bus_arbiter_rr_if #(
    parameter int NUM_MASTERS = 2
);
    localparam int OWN_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] _BR;
    logic [NUM_MASTERS-1:0] _BGACK;
    logic                   _AS;
    logic [NUM_MASTERS-1:0] _BG;
    logic [OWN_W-1:0]       OWNER;
    logic                   BUSY;
    logic                   TIMEOUT;
    logic                   PROTO_ERR;

    modport slave (
        input  _BR, _BGACK, _AS,
        output _BG, OWNER, BUSY, TIMEOUT, PROTO_ERR
    );

    modport master (
        output _BR, _BGACK, _AS,
        input  _BG, OWNER, BUSY, TIMEOUT, PROTO_ERR
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// N-master round-robin BR/BG/BGACK arbiter for the 68030-style local bus with
// idle gating, grant timeout and protocol-error detection.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS   = 2,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic             SCLK,
    input  logic             _RST,
    bus_arbiter_rr_if.slave  bus
);
    localparam int OWN_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TMR_W = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0);
    localparam logic [TMR_W-1:0] TMR_SAT  = {TMR_W{1'b1}};
    localparam logic [OWN_W-1:0] IDX_TOP  = OWN_W'(NUM_MASTERS - 1);
    localparam bit TIMEOUT_ON = (GRANT_TIMEOUT != 0);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_OWNED} state_t;

    state_t                 state_r;
    logic [OWN_W-1:0]       win_r;
    logic [OWN_W-1:0]       last_r;
    logic [TMR_W-1:0]       tmr_r;
    logic [NUM_MASTERS-1:0] bg_r;
    logic [OWN_W-1:0]       owner_r;
    logic                   busy_r;
    logic                   timeout_r;
    logic                   proto_err_r;

    logic [NUM_MASTERS-1:0] req_s;
    logic [NUM_MASTERS-1:0] ack_s;
    logic [NUM_MASTERS-1:0] win_mask_s;
    logic [OWN_W-1:0]       pick_s;
    logic                   can_grant_s;
    logic                   proto_s;

    // First requester strictly after 'last', wrapping; scan visits 'last' itself last.
    function automatic logic [OWN_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                 input logic [OWN_W-1:0]       last);
        logic [OWN_W-1:0] cand;
        logic [OWN_W-1:0] pick;
        logic             found;
        cand  = last;
        pick  = {OWN_W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = (cand == IDX_TOP) ? {OWN_W{1'b0}} : cand + OWN_W'(1);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Request decode, winner selection and protocol-violation detection.
    always_comb begin
        req_s       = ~bus._BR;
        ack_s       = ~bus._BGACK;
        win_mask_s  = NUM_MASTERS'(1) << win_r;
        pick_s      = rr_pick(req_s, last_r);
        can_grant_s = (|req_s) && bus._AS && !(|ack_s);
        proto_s     = 1'b0;
        case (state_r)
            ST_IDLE:  proto_s = |ack_s;
            ST_GRANT: proto_s = |(ack_s & ~win_mask_s);
            ST_OWNED: proto_s = |(ack_s & ~win_mask_s);
            default:  proto_s = 1'b0;
        endcase
    end

    // Arbitration FSM with all bus-visible outputs registered.
    always_ff @(posedge SCLK or negedge _RST) begin
        if (!_RST) begin
            state_r     <= ST_IDLE;
            win_r       <= {OWN_W{1'b0}};
            last_r      <= IDX_TOP;
            tmr_r       <= {TMR_W{1'b0}};
            bg_r        <= {NUM_MASTERS{1'b1}};
            owner_r     <= {OWN_W{1'b0}};
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            timeout_r   <= 1'b0;
            proto_err_r <= proto_s;
            case (state_r)
                ST_IDLE: begin
                    if (can_grant_s) begin
                        bg_r    <= ~(NUM_MASTERS'(1) << pick_s);
                        win_r   <= pick_s;
                        owner_r <= pick_s;
                        tmr_r   <= {TMR_W{1'b0}};
                        state_r <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Acknowledge beats withdrawal, which beats timeout.
                    if (ack_s[win_r]) begin
                        bg_r    <= {NUM_MASTERS{1'b1}};
                        last_r  <= win_r;
                        busy_r  <= 1'b1;
                        state_r <= ST_OWNED;
                    end else if (!req_s[win_r]) begin
                        bg_r    <= {NUM_MASTERS{1'b1}};
                        state_r <= ST_IDLE;
                    end else if (TIMEOUT_ON && (tmr_r == TMR_LAST)) begin
                        bg_r      <= {NUM_MASTERS{1'b1}};
                        timeout_r <= 1'b1;
                        last_r    <= win_r;
                        state_r   <= ST_IDLE;
                    end else if (tmr_r != TMR_SAT) begin
                        tmr_r <= tmr_r + TMR_W'(1);
                    end
                end
                ST_OWNED: begin
                    if (!ack_s[win_r]) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    bg_r    <= {NUM_MASTERS{1'b1}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus._BG       = bg_r;
    assign bus.OWNER     = owner_r;
    assign bus.BUSY      = busy_r;
    assign bus.TIMEOUT   = timeout_r;
    assign bus.PROTO_ERR = proto_err_r;
endmodule
